// File: rtl/tanimoto_comparator_array_pkg.sv
// tanimoto_pkg: popcount width helper, pipeline depth and per-lane flag type shared by the comparator files
package tanimoto_pkg;
  localparam int STAGES = 3;
  function automatic int cnt_width(input int vector_width);
    return $clog2(vector_width + 1);
  endfunction
  typedef struct packed {
    logic zero;
    logic err;
  } lane_flags_t;
endpackage

// File: rtl/tanimoto_comparator_array_if.sv
// tanimoto_comparator_array_if: beat/result bus (i_* threshold write, counts, id, valid, result ready; o_* ready, valid, match, id; o_MatchCnt/o_ErrCnt with TANIMOTO_STATS_EN)
interface tanimoto_comparator_array_if
  import tanimoto_pkg::*;
#(
  parameter int VECTOR_WIDTH = 920,
  parameter int N_LANES = 4,
  parameter int FRAC_BITS = 8,
  parameter int ID_WIDTH = 16
);
  localparam int CNT_WIDTH = cnt_width(VECTOR_WIDTH);
  logic i_WrThreshold;
  logic [FRAC_BITS-1:0] i_Threshold;
  logic i_Valid, o_Ready, o_Valid, i_Ready;
  logic [N_LANES*CNT_WIDTH-1:0] i_CntA, i_CntB, i_CntC;
  logic [ID_WIDTH-1:0] i_Id, o_Id;
  logic [N_LANES-1:0] o_Match;
`ifdef TANIMOTO_STATS_EN
  logic [31:0] o_MatchCnt;
  logic [15:0] o_ErrCnt;
  modport slave(
    input i_WrThreshold, i_Threshold, i_Valid, i_CntA, i_CntB, i_CntC, i_Id, i_Ready,
    output o_Ready, o_Valid, o_Match, o_Id, o_MatchCnt, o_ErrCnt
  );
  modport master(
    output i_WrThreshold, i_Threshold, i_Valid, i_CntA, i_CntB, i_CntC, i_Id, i_Ready,
    input o_Ready, o_Valid, o_Match, o_Id, o_MatchCnt, o_ErrCnt
  );
`else
  modport slave(
    input i_WrThreshold, i_Threshold, i_Valid, i_CntA, i_CntB, i_CntC, i_Id, i_Ready,
    output o_Ready, o_Valid, o_Match, o_Id
  );
  modport master(
    output i_WrThreshold, i_Threshold, i_Valid, i_CntA, i_CntB, i_CntC, i_Id, i_Ready,
    input o_Ready, o_Valid, o_Match, o_Id
  );
`endif
endinterface

// File: rtl/tanimoto_comparator_array_lane.sv
// tanimoto_lane: S1 union/consistency and S2 products for one lane (clk, rstn, en in; a/b/c/t in; lhs=C<<F, rhs=T*U, flags out)
module tanimoto_lane
  import tanimoto_pkg::*;
#(
  parameter int CNT_WIDTH = 10,
  parameter int FRAC_BITS = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic [CNT_WIDTH-1:0] a,
  input  logic [CNT_WIDTH-1:0] b,
  input  logic [CNT_WIDTH-1:0] c,
  input  logic [FRAC_BITS-1:0] t,
  output logic [CNT_WIDTH+FRAC_BITS:0] lhs,
  output logic [CNT_WIDTH+FRAC_BITS:0] rhs,
  output lane_flags_t flags
);
  localparam int PW = CNT_WIDTH + FRAC_BITS + 1;
  logic [CNT_WIDTH:0] u_d, u;
  logic [CNT_WIDTH-1:0] c_q;
  logic [FRAC_BITS-1:0] t_q;
  lane_flags_t f_q;
  assign u_d = {1'b0, a} + {1'b0, b} - {1'b0, c};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u <= '0;
      c_q <= '0;
      t_q <= '0;
      f_q <= '0;
      lhs <= '0;
      rhs <= '0;
      flags <= '0;
    end else if (en) begin
      u <= u_d;
      c_q <= c;
      t_q <= t;
      f_q <= '{zero: u_d == '0, err: c > a || c > b};
      lhs <= PW'(c_q) << FRAC_BITS;
      rhs <= PW'(t_q) * PW'(u);
      flags <= f_q;
    end
  end
endmodule

// File: rtl/tanimoto_comparator_array.sv
// tanimoto_comparator_array: N_LANES 3-stage Tanimoto threshold compare (clk, rstn async low, bus slave modport); TANIMOTO_STATS_EN adds o_MatchCnt/o_ErrCnt
module tanimoto_comparator_array
  import tanimoto_pkg::*;
#(
  parameter int VECTOR_WIDTH = 920,
  parameter int N_LANES = 4,
  parameter int FRAC_BITS = 8,
  parameter int THRESH_RESET = 205,
  parameter int ID_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  tanimoto_comparator_array_if.slave bus
);
  localparam int CW = cnt_width(VECTOR_WIDTH);
  localparam int PW = CW + FRAC_BITS + 1;
  logic en;
  logic [FRAC_BITS-1:0] thr;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0][ID_WIDTH-1:0] id_p;
  logic [N_LANES-1:0][PW-1:0] lhs, rhs;
  lane_flags_t [N_LANES-1:0] flags;
  logic [N_LANES-1:0] match_d, match_q;
  assign en = !vld[STAGES-1] || bus.i_Ready;
  assign bus.o_Ready = en;
  assign bus.o_Valid = vld[STAGES-1];
  assign bus.o_Match = match_q;
  assign bus.o_Id = id_p[STAGES-1];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) thr <= FRAC_BITS'(THRESH_RESET);
    else if (bus.i_WrThreshold) thr <= bus.i_Threshold;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      id_p <= '0;
      match_q <= '0;
    end else if (en) begin
      vld <= {vld[STAGES-2:0], bus.i_Valid};
      id_p <= {id_p[STAGES-2:0], bus.i_Id};
      match_q <= match_d;
    end
  end
  always_comb begin
    match_d = '0;
    for (int i = 0; i < N_LANES; i++) match_d[i] = !flags[i].zero && !flags[i].err && lhs[i] >= rhs[i];
  end
  for (genvar k = 0; k < N_LANES; k++) begin : lane_g
    tanimoto_lane #(.CNT_WIDTH(CW), .FRAC_BITS(FRAC_BITS)) u_lane (
      .clk(clk),
      .rstn(rstn),
      .en(en),
      .a(bus.i_CntA[k*CW +: CW]),
      .b(bus.i_CntB[k*CW +: CW]),
      .c(bus.i_CntC[k*CW +: CW]),
      .t(thr),
      .lhs(lhs[k]),
      .rhs(rhs[k]),
      .flags(flags[k])
    );
  end
`ifdef TANIMOTO_STATS_EN
  localparam int NW = $clog2(N_LANES + 1);
  logic [31:0] match_cnt;
  logic [15:0] err_cnt;
  logic [NW-1:0] n_match, n_err;
  logic [32:0] match_sum;
  logic [16:0] err_sum;
  always_comb begin
    n_match = '0;
    n_err = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_match = n_match + NW'(match_q[i]);
      n_err = n_err + NW'(flags[i].err);
    end
    match_sum = {1'b0, match_cnt} + 33'(n_match);
    err_sum = {1'b0, err_cnt} + 17'(n_err);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (bus.o_Valid && bus.i_Ready) match_cnt <= match_sum[32] ? '1 : match_sum[31:0];
      if (en && vld[STAGES-2]) err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end
  assign bus.o_MatchCnt = match_cnt;
  assign bus.o_ErrCnt = err_cnt;
`endif
endmodule

// File: doc/tanimoto_comparator_array.md
TANIMOTO_COMPARATOR_ARRAY -- requirements
Module: tanimoto_comparator_array

Interface
REQ-001 SHALL have parameter VECTOR_WIDTH, default 920, giving the fingerprint bit width; CNT_WIDTH = $clog2(VECTOR_WIDTH+1).
REQ-002 SHALL have parameter N_LANES, default 4, giving the number of parallel compare lanes.
REQ-003 SHALL have parameter FRAC_BITS, default 8, giving the threshold fraction bits; threshold value = T/2^FRAC_BITS.
REQ-004 SHALL have parameter THRESH_RESET, default 205 (~0.80), giving the threshold register reset value.
REQ-005 SHALL have parameter ID_WIDTH, default 16, giving the sideband tag width.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_WrThreshold, input, 1 bit: threshold write strobe.
REQ-009 SHALL have port i_Threshold, input, FRAC_BITS: new threshold T.
REQ-010 SHALL have port i_Valid, input, 1 bit: input beat valid.
REQ-011 SHALL have port o_Ready, output, 1 bit: input beat accepted when i_Valid&&o_Ready.
REQ-012 SHALL have ports i_CntA, i_CntB and i_CntC, input, N_LANES*CNT_WIDTH each: per-lane popcounts |A|, |B| and |A&B|; lane k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
REQ-013 SHALL have port i_Id, input, ID_WIDTH: tag carried with the beat.
REQ-014 SHALL have port o_Valid, output, 1 bit: result valid.
REQ-015 SHALL have port i_Ready, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port o_Match, output, N_LANES: per-lane 1 = similarity >= threshold.
REQ-017 SHALL have port o_Id, output, ID_WIDTH: tag of the result beat.

Function
REQ-018 SHALL compute per lane U = A+B-C at CNT_WIDTH+1 bits; match = (U!=0) && ((C<<FRAC_BITS) >= T*U), all products at full width with no truncation.
REQ-019 SHALL force match=0 when U==0 (A=B=C=0) or when C>A or C>B (inconsistent input).
REQ-020 SHALL use a 3-stage pipeline (S1 union/check, S2 multiply, S3 compare/register); latency 3 cycles from acceptance to o_Valid when i_Ready is held high.
REQ-021 SHALL define global advance en = !o_Valid || i_Ready; o_Ready = en; all stages hold when en=0; throughput 1 beat/cycle; bubbles are not collapsed.
REQ-022 SHALL keep o_Match and o_Id stable while o_Valid && !i_Ready.
REQ-023 SHALL load the threshold register on i_WrThreshold at any time, including mid-stream; each beat latches the T in effect at its acceptance into S1; a beat accepted in the same cycle as a write uses the old T.
REQ-024 SHALL treat i_Threshold=0 as match for every lane with U!=0 and consistent counts.

Reset
REQ-025 SHALL, on rstn low, asynchronously clear o_Valid, all stage valids, o_Match and o_Id, and set threshold = THRESH_RESET; o_Ready = 1 from the first cycle after release.
REQ-026 SHALL drop in-flight beats on reset mid-operation, with no output for them.

Configuration
REQ-027 SHALL, with macro TANIMOTO_STATS_EN defined, add outputs o_MatchCnt[31:0] (total matched lanes over handshaken results, saturating) and o_ErrCnt[15:0] (lanes failing the REQ-019 consistency check, saturating), both cleared by reset; without the macro these ports and counters SHALL not exist.

Structure
REQ-028 SHALL place CNT_WIDTH computation, stage count and the lane result struct/typedef in package tanimoto_pkg.
REQ-029 SHALL implement one lane as sub-module tanimoto_lane (S1-S2 datapath), instantiated N_LANES times under shared control.

Verification (FRAC_BITS=8, T=205, N_LANES=4)
REQ-030 SHALL check lanes {33,17,17},{35,35,35},{24,0,0},{0,0,0} -> o_Match=4'b0010, 3 cycles after acceptance.
REQ-031 SHALL check T=0 with a beat containing {8,5,1} and {0,0,0} -> matching lane=1, zero lane=0.
REQ-032 SHALL check 8 back-to-back beats with i_Ready low for 4 cycles mid-stream -> no loss or duplication, o_Id order preserved, o_Ready low while stalled.
REQ-033 SHALL check i_WrThreshold=255 in the same cycle as beat {35,35,35} -> that beat matches (old T); the next identical beat also matches; the next beat {33,17,17} -> 0.
REQ-034 SHALL check rstn asserted with 2 beats in flight -> o_Valid=0 immediately; threshold=205; no stale outputs after release.
REQ-035 SHALL check, with TANIMOTO_STATS_EN, {5,3,4} in a lane -> match 0, o_ErrCnt increments by 1.
